// File: rtl/seqdiv16x8.sv
// seqdiv16x8: restoring shift-subtract divider, 16-bit dividend by 8-bit divisor.
// One quotient bit per clock. Results are registered and held until the next
// accepted start. A zero divisor short-circuits straight to DONE.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | 16 shift-subtract iterations in flight; busy=1
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module seqdiv16x8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] n;
  logic [15:0] q_sh;
  logic [7:0]  d;
  logic [8:0]  r;
  logic [4:0]  count;

  logic        accept;
  logic        last_iter;
  logic [8:0]  trial;
  logic        q_bit;
  logic [8:0]  r_nxt;
  logic [15:0] q_nxt;

  // r never exceeds d-1, so r[8] is always clear and only r[7:0] feeds the shift
  assign accept    = start && (state != RUN);
  assign last_iter = (count == 5'd15);
  assign trial     = {r[7:0], n[15]};
  assign q_bit     = (trial >= {1'b0, d});
  assign r_nxt     = q_bit ? (trial - {1'b0, d}) : trial;
  assign q_nxt     = {q_sh[14:0], q_bit};

  // status outputs are pure decodes of the state register
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (divisor == 8'd0) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      RUN: begin
        if (last_iter) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // operand latch, shift-subtract datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n         <= 16'h0000;
      d         <= 8'h00;
      r         <= 9'h000;
      q_sh      <= 16'h0000;
      count     <= 5'd0;
      quotient  <= 16'h0000;
      remainder <= 8'h00;
      div_zero  <= 1'b0;
    end else if (accept) begin
      n     <= dividend;
      d     <= divisor;
      r     <= 9'h000;
      q_sh  <= 16'h0000;
      count <= 5'd0;
      if (divisor == 8'd0) begin
        quotient  <= 16'hFFFF;
        remainder <= dividend[7:0];
        div_zero  <= 1'b1;
      end
    end else if (state == RUN) begin
      n     <= {n[14:0], 1'b0};
      r     <= r_nxt;
      q_sh  <= q_nxt;
      count <= count + 5'd1;
      if (last_iter) begin
        quotient  <= q_nxt;
        remainder <= r_nxt[7:0];
        div_zero  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seqdiv16x8.sv
// tb_seqdiv16x8: directed and random checks of the sequential divider.
module tb_seqdiv16x8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  seqdiv16x8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [15:0] a, input logic [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick;
  endtask

  // edges after the accepting edge until done is seen, plus busy-high samples
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick;
      lat++;
    end
  endtask

  int          lat, bcnt, t_prev;
  bit          seen_done;
  logic [15:0] ra;
  logic [7:0]  rb;
  logic [31:0] prod;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 16'h0000;
    divisor  = 8'h00;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", div_zero, 0);
    rst_n = 1'b1;
    tick;

    // 1000 / 7 = 142 rem 6
    accept(16'd1000, 8'd7);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("basic_lat", lat, 16);
    chk("basic_busy_cycles", bcnt, 16);
    chk("basic_busy_in_done", busy, 0);
    chk("basic_quot", quotient, 142);
    chk("basic_rem", remainder, 6);
    chk("basic_dz", div_zero, 0);
    tick;
    chk("done_one_cycle", done, 0);

    // back-to-back with start held high
    accept(16'hFFFF, 8'h01);
    wait_done(lat, bcnt);
    chk("b2b1_lat", lat, 16);
    chk("b2b1_quot", quotient, 16'hFFFF);
    chk("b2b1_rem", remainder, 0);
    t_prev = cyc;
    accept(16'hFFFF, 8'hFF);
    wait_done(lat, bcnt);
    chk("b2b2_spacing", cyc - t_prev, 17);
    chk("b2b2_quot", quotient, 16'h0101);
    chk("b2b2_rem", remainder, 0);
    t_prev = cyc;
    accept(16'd5, 8'd9);
    wait_done(lat, bcnt);
    chk("b2b3_spacing", cyc - t_prev, 17);
    chk("b2b3_quot", quotient, 0);
    chk("b2b3_rem", remainder, 5);
    start = 1'b0;
    tick;

    // divide by zero
    accept(16'h1234, 8'h00);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("dz_lat", lat, 0);
    chk("dz_busy_cycles", bcnt, 0);
    chk("dz_quot", quotient, 16'hFFFF);
    chk("dz_rem", remainder, 8'h34);
    chk("dz_flag", div_zero, 1);
    tick;

    // 20 / 3 clears div_zero; outputs hold the old result during RUN
    accept(16'd20, 8'd3);
    start = 1'b0;
    chk("hold_quot_in_run", quotient, 16'hFFFF);
    chk("hold_dz_in_run", div_zero, 1);
    wait_done(lat, bcnt);
    chk("after_dz_quot", quotient, 6);
    chk("after_dz_rem", remainder, 2);
    chk("after_dz_flag", div_zero, 0);
    tick;

    // start while busy is ignored
    accept(16'd100, 8'd10);
    start = 1'b0;
    repeat (4) tick;
    dividend = 16'd200;
    divisor  = 8'd3;
    start    = 1'b1;
    tick;
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("busy_start_lat", lat + 5, 16);
    chk("busy_start_quot", quotient, 10);
    chk("busy_start_rem", remainder, 0);
    tick;

    // asynchronous reset in the middle of a run
    accept(16'd1000, 8'd7);
    start = 1'b0;
    repeat (7) tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quot", quotient, 0);
    chk("midrst_rem", remainder, 0);
    chk("midrst_dz", div_zero, 0);
    seen_done = 1'b0;
    repeat (3) begin
      tick;
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      tick;
      if (done) seen_done = 1'b1;
    end
    chk("midrst_no_done", seen_done, 0);
    accept(16'd255, 8'd16);
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("post_rst_lat", lat, 16);
    chk("post_rst_quot", quotient, 15);
    chk("post_rst_rem", remainder, 15);
    tick;

    // random nonzero divisors against arithmetic and the division invariant
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom_range(1, 255));
      accept(ra, rb);
      start = 1'b0;
      wait_done(lat, bcnt);
      chk("rnd_lat", lat, 16);
      chk("rnd_quot", quotient, ra / rb);
      chk("rnd_rem", remainder, ra % rb);
      prod = 32'(quotient) * 32'(rb) + 32'(remainder);
      chk("rnd_invariant", prod, 32'(ra));
      chk("rnd_rem_lt_div", 32'(remainder < rb), 1);
      chk("rnd_dz", div_zero, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
